// File: rtl/demux2_route.sv
// Two-way demultiplexer feeding two independent 2-entry FIFOs, one per output channel.
// Define DEMUX2_ROUTE_CNT_EN to add the per-channel accepted-byte counters cnt0/cnt1.
module demux2_route #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX2_ROUTE_CNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);

  logic [WIDTH-1:0] mem [2][2];
  logic [1:0]       occ [2];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;

  assign full[0] = (occ[0] == 2'd2);
  assign full[1] = (occ[1] == 2'd2);

  // Readiness looks only at the selected channel, so a full channel never stalls the other.
  assign in_ready = rst_n & (in_sel ? ~full[1] : ~full[0]);

  assign push[0] = in_valid & in_ready & ~in_sel;
  assign push[1] = in_valid & in_ready &  in_sel;
  assign pop[0]  = (occ[0] != 2'd0) & out0_ready;
  assign pop[1]  = (occ[1] != 2'd0) & out1_ready;

  assign out0_valid = (occ[0] != 2'd0);
  assign out1_valid = (occ[1] != 2'd0);
  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 2'b00;
      rd_ptr <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        occ[c] <= 2'd0;
        // NOTE: storage is cleared on reset so the data outputs read zero while empty after reset.
        mem[c][0] <= '0;
        mem[c][1] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= in_data;
          wr_ptr[c]         <= ~wr_ptr[c];
        end
        if (pop[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
        end
        case ({push[c], pop[c]})
          2'b10:   occ[c] <= occ[c] + 2'd1;
          2'b01:   occ[c] <= occ[c] - 2'd1;
          default: occ[c] <= occ[c];
        endcase
      end
    end
  end

`ifdef DEMUX2_ROUTE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (push[0]) cnt0 <= cnt0 + 8'd1;
      if (push[1]) cnt1 <= cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux2_route.sv
// Bench for demux2_route: queue-based channel model compared every cycle, plus directed literal checks.
module tb_demux2_route;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;
`ifdef DEMUX2_ROUTE_CNT_EN
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  demux2_route #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX2_ROUTE_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge only, so they are stable around every rising edge.
  task automatic cyc(input logic rst, input logic v, input logic sel, input logic [W-1:0] d,
                     input logic r0, input logic r1);
    @(negedge clk);
    rst_n      = rst;
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each channel is a plain queue of at most two bytes.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [7:0]   m_cnt0 = 8'd0;
  logic [7:0]   m_cnt1 = 8'd0;
  bit           armed  = 1'b0;

  always @(posedge clk) begin
    bit rdy, p0, p1, u0, u1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 8'd0;
      m_cnt1 = 8'd0;
      armed  = 1'b1;
    end else begin
      rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
      u0  = (q0.size() > 0) && out0_ready;
      u1  = (q1.size() > 0) && out1_ready;
      p0  = in_valid && rdy && !in_sel;
      p1  = in_valid && rdy &&  in_sel;
      if (u0) void'(q0.pop_front());
      if (u1) void'(q1.pop_front());
      if (p0) begin q0.push_back(in_data); m_cnt0 = m_cnt0 + 8'd1; end
      if (p1) begin q1.push_back(in_data); m_cnt1 = m_cnt1 + 8'd1; end
    end
    #1;
    if (armed) begin
      check("m_ready", 32'(in_ready),
            32'(rst_n && (in_sel ? (q1.size() < 2) : (q0.size() < 2))));
      check("m_v0", 32'(out0_valid), 32'(q0.size() > 0));
      check("m_v1", 32'(out1_valid), 32'(q1.size() > 0));
      if (q0.size() > 0) check("m_d0", 32'(out0_data), 32'(q0[0]));
      if (q1.size() > 0) check("m_d1", 32'(out1_data), 32'(q1[0]));
`ifdef DEMUX2_ROUTE_CNT_EN
      check("m_cnt0", 32'(cnt0), 32'(m_cnt0));
      check("m_cnt1", 32'(cnt1), 32'(m_cnt1));
`endif
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);

    // Reset then idle
    cyc(1, 0, 0, 8'h00, 0, 0);
    after_edge();
    check("rst_v0", 32'(out0_valid), 32'h0);
    check("rst_v1", 32'(out1_valid), 32'h0);
    check("rst_d0", 32'(out0_data), 32'h00);
    check("rst_d1", 32'(out1_data), 32'h00);
    check("rst_rdy", 32'(in_ready), 32'h1);

    // Single byte to channel 0, visible for exactly one cycle
    cyc(1, 1, 0, 8'hA5, 1, 1);
    after_edge();
    check("a5_v0", 32'(out0_valid), 32'h1);
    check("a5_d0", 32'(out0_data), 32'hA5);
    check("a5_v1", 32'(out1_valid), 32'h0);
    cyc(1, 0, 1, 8'h5A, 1, 1);
    after_edge();
    check("a5_gone", 32'(out0_valid), 32'h0);

    // Fill channel 1, channel 0 still accepts
    cyc(1, 1, 1, 8'h11, 1, 0);
    cyc(1, 1, 1, 8'h22, 1, 0);
    cyc(1, 0, 1, 8'h00, 1, 0);
    after_edge();
    check("full_rdy1", 32'(in_ready), 32'h0);
    cyc(1, 1, 0, 8'h33, 0, 0);
    after_edge();
    check("rdy_sel0", 32'(in_ready), 32'h1);
    check("d0_33", 32'(out0_data), 32'h33);
    check("d1_11", 32'(out1_data), 32'h11);
    // Push to full channel 1 while it pops: must be refused
    cyc(1, 1, 1, 8'h66, 1, 1);
    after_edge();
    check("d1_22", 32'(out1_data), 32'h22);
    check("v0_popped", 32'(out0_valid), 32'h0);
    cyc(1, 0, 0, 8'h00, 1, 1);
    after_edge();
    check("v1_empty", 32'(out1_valid), 32'h0);

    // Simultaneous push/pop on channel 0 across pointer wrap
    cyc(1, 1, 0, 8'h40, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, W'(8'h44 + i), 1, 0);
      after_edge();
      check("pp_d0", 32'(out0_data), 32'(8'h44 + i));
      check("pp_v0", 32'(out0_valid), 32'h1);
    end
    cyc(1, 0, 1, 8'hFF, 1, 0);
    after_edge();
    check("pp_drain", 32'(out0_valid), 32'h0);

    // Reset while channel 0 is full and a push/pop is offered
    cyc(1, 1, 0, 8'h01, 0, 0);
    cyc(1, 1, 0, 8'h02, 0, 0);
    cyc(0, 1, 0, 8'h03, 1, 1);
    after_edge();
    check("mr_v0", 32'(out0_valid), 32'h0);
    check("mr_v1", 32'(out1_valid), 32'h0);
    check("mr_rdy", 32'(in_ready), 32'h0);
    check("mr_d0", 32'(out0_data), 32'h00);
`ifdef DEMUX2_ROUTE_CNT_EN
    check("mr_cnt0", 32'(cnt0), 32'h0);
`endif
    cyc(1, 0, 0, 8'h00, 0, 0);
    after_edge();
    check("mr_rdy1", 32'(in_ready), 32'h1);
    check("mr_v0b", 32'(out0_valid), 32'h0);

    // 257 accepts to channel 1 with a draining consumer
    for (int i = 0; i < 257; i++) begin
      cyc(1, 1, 1, W'(i), 0, 1);
    end
    cyc(1, 0, 0, 8'h00, 0, 1);
    after_edge();
    check("c_v1", 32'(out1_valid), 32'h0);
`ifdef DEMUX2_ROUTE_CNT_EN
    check("cnt1_wrap", 32'(cnt1), 32'h1);
    check("cnt0_zero", 32'(cnt0), 32'h0);
`endif

    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux2_route.md
DEMUX2_ROUTE -- requirements
Module: demux2_route

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and both output channels in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_data  input  WIDTH  byte offered by the producer.
REQ-005 Port: in_sel  input  1  destination select; 0 routes to channel 0, 1 routes to channel 1.
REQ-006 Port: in_valid  input  1  producer asserts when in_data/in_sel are valid.
REQ-007 Port: in_ready  output  1  block can accept the offered byte this cycle.
REQ-008 Port: out0_data  output  WIDTH  head byte of channel 0.
REQ-009 Port: out0_valid  output  1  channel 0 holds at least one byte.
REQ-010 Port: out0_ready  input  1  channel 0 consumer accepts head byte.
REQ-011 Ports out1_data, out1_valid, out1_ready SHALL mirror REQ-008..010 for channel 1.

Function
REQ-012 Each channel SHALL contain an independent 2-entry FIFO with registered storage, 2-bit occupancy count (0..2), 1-bit read and write pointers.
REQ-013 in_ready SHALL equal "FIFO selected by in_sel is not full", combinationally from in_sel and occupancy, forced 0 while rst_n is low.
REQ-014 Accept occurs on a rising edge with in_valid=1 and in_ready=1; byte is written into the FIFO selected by in_sel; other FIFO is not written.
REQ-015 Latency: an accepted byte entering an empty FIFO SHALL appear on outN_data with outN_valid=1 in the cycle after acceptance; no same-cycle bypass.
REQ-016 outN_valid SHALL be 1 exactly when occupancy of channel N is nonzero; outN_data SHALL be the oldest stored byte.
REQ-017 Pop occurs on a rising edge with outN_valid=1 and outN_ready=1; read pointer advances, occupancy decrements.
REQ-018 Simultaneous push and pop on the same non-full channel SHALL leave occupancy unchanged and preserve order.
REQ-019 Full channel: in_ready=0 for that selection even if a pop occurs the same cycle; no write when full, no read when empty.
REQ-020 Pointers SHALL wrap 1->0; byte order within a channel SHALL be preserved across wrap; no ordering relation across channels.
REQ-021 A full channel SHALL NOT block acceptance for the other channel (in_ready follows in_sel each cycle).
REQ-022 in_sel and in_data changes while in_valid=0 SHALL have no effect on state.

Reset
REQ-023 On a rising edge with rst_n=0: both occupancies 0, all pointers 0, storage cleared to 0; out0_valid=out1_valid=0, out0_data=out1_data=0.
REQ-024 Reset mid-operation SHALL discard all stored bytes; a concurrent accept or pop in that cycle SHALL be ignored.
REQ-025 First accept possible on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro DEMUX2_ROUTE_CNT_EN defined: add outputs cnt0 and cnt1 (8 bits each), counting accepted bytes per channel, incremented on each accept to that channel, wrapping 255->0, reset to 0.
REQ-027 Macro DEMUX2_ROUTE_CNT_EN undefined: cnt0/cnt1 ports and counter logic are absent; all other behaviour identical.

Verification
REQ-028 Reset then idle -> out0_valid=out1_valid=0, out0_data=out1_data=8'h00, in_ready=1 after rst_n rises.
REQ-029 Push 8'hA5 sel=0, out0_ready=1 -> out0_valid=1, out0_data=8'hA5 next cycle only; channel 1 stays invalid.
REQ-030 out1_ready=0, push 8'h11,8'h22 sel=1 -> in_ready=0 for sel=1, in_ready=1 for sel=0; 8'h33 sel=0 accepted; then out1_ready=1 pops 8'h11 then 8'h22.
REQ-031 Channel 0 occupancy 1, push 8'h44 and pop same cycle repeated 5 times (values 44..48) -> occupancy stays 1, pops emerge in order across pointer wrap.
REQ-032 Channel 0 full with 8'h01,8'h02, assert rst_n=0 one cycle with in_valid=1 -> both channels empty, no byte accepted; with DEMUX2_ROUTE_CNT_EN, cnt0=0.
REQ-033 With DEMUX2_ROUTE_CNT_EN, 257 accepts to channel 1 (out1_ready=1) -> cnt1=1, cnt0=0.
